// File: rtl/tap_mac_sequencer_if.sv
// Bus bundle between the tap MAC sequencer and its environment (sample stream,
// delay-line hookup, coefficient port, result and error flags).
interface tap_mac_sequencer_if #(
   parameter int DATA_W   = 16,
   parameter int NUM_TAPS = 8
);
   logic                       sample_valid;
   logic [DATA_W-1:0]          sample_in;
   logic                       shift_en;
   logic [DATA_W-1:0]          shift_data;
   logic [DATA_W*NUM_TAPS-1:0] taps_in;
   logic                       coef_we;
   logic [2:0]                 coef_addr;
   logic [DATA_W-1:0]          coef_data;
   logic                       busy;
   logic                       out_valid;
   logic [DATA_W-1:0]          out_sample;
   logic [1:0]                 err;
   logic                       err_clr;

   modport master (
      output sample_valid, sample_in, taps_in, coef_we, coef_addr, coef_data, err_clr,
      input  shift_en, shift_data, busy, out_valid, out_sample, err
   );

   modport slave (
      input  sample_valid, sample_in, taps_in, coef_we, coef_addr, coef_data, err_clr,
      output shift_en, shift_data, busy, out_valid, out_sample, err
   );
endinterface

// File: rtl/tap_mac_sequencer.sv
// Sequences one sample through an external tapped delay line and a serial
// multiply-accumulate over NUM_TAPS Q1.15 coefficients, one tap per cycle.
//
// state  | meaning
// IDLE   | waiting for sample_valid; coefficient writes accepted
// SHIFT  | shift_en to the delay line with the captured sample
// SETTLE | delay-line taps update; accumulator and tap index cleared
// MAC    | acc += tap_k * coef_k, k = 0..NUM_TAPS-1
// OUT    | out_valid strobe; out_sample holds the saturated result
module tap_mac_sequencer #(
   parameter int DATA_W   = 16,
   parameter int NUM_TAPS = 8,
   parameter int ACC_W    = 35
) (
   input logic               clock,
   input logic               reset_n,
   tap_mac_sequencer_if.slave bus
);
   localparam int K_W    = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
   localparam int PROD_W = 2 * DATA_W;
   localparam int FRAC_W = 15;

   localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

   typedef enum logic [2:0] {
      IDLE,
      SHIFT,
      SETTLE,
      MAC,
      OUT
   } state_t;

   state_t                   state;
   state_t                   state_nxt;
   logic [K_W-1:0]           k;
   logic signed [ACC_W-1:0]  acc;
   logic signed [DATA_W-1:0] coef [NUM_TAPS];
   logic [DATA_W-1:0]        shift_data_q;
   logic [DATA_W-1:0]        out_sample_q;
   logic [1:0]               err_q;

   logic                     busy;
   logic                     last_tap;
   logic                     coef_addr_ok;
   logic                     overrun;
   logic                     coef_drop;
   logic signed [DATA_W-1:0] tap_sel;
   logic signed [DATA_W-1:0] coef_sel;
   logic signed [PROD_W-1:0] prod;
   logic signed [ACC_W-1:0]  acc_sum;
   logic signed [ACC_W-1:0]  acc_shr;
   logic [DATA_W-1:0]        sat_val;

   assign busy         = (state != IDLE);
   assign last_tap     = (k == K_W'(NUM_TAPS - 1));
   assign coef_addr_ok = (int'(bus.coef_addr) < NUM_TAPS);
   assign overrun      = bus.sample_valid && busy;
   assign coef_drop    = bus.coef_we && busy && coef_addr_ok;

   assign bus.busy       = busy;
   assign bus.shift_en   = (state == SHIFT);
   assign bus.out_valid  = (state == OUT);
   assign bus.shift_data = shift_data_q;
   assign bus.out_sample = out_sample_q;
   assign bus.err        = err_q;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.sample_valid) state_nxt = SHIFT;
         SHIFT:   state_nxt = SETTLE;
         SETTLE:  state_nxt = MAC;
         MAC:     if (last_tap) state_nxt = OUT;
         OUT:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      tap_sel  = '0;
      coef_sel = '0;
      for (int i = 0; i < NUM_TAPS; i++) begin
         if (k == K_W'(i)) begin
            tap_sel  = $signed(bus.taps_in[DATA_W*i +: DATA_W]);
            coef_sel = coef[i];
         end
      end
   end

   // Full-width signed product, sign-extended into the accumulator; the
   // accumulator is sized so it cannot wrap, saturation happens only on output.
   assign prod    = tap_sel * coef_sel;
   assign acc_sum = acc + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
   assign acc_shr = acc_sum >>> FRAC_W;

   always_comb begin
      if (acc_shr > SAT_MAX)      sat_val = {1'b0, {(DATA_W-1){1'b1}}};
      else if (acc_shr < SAT_MIN) sat_val = {1'b1, {(DATA_W-1){1'b0}}};
      else                        sat_val = acc_shr[DATA_W-1:0];
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         shift_data_q <= '0;
         out_sample_q <= '0;
         acc          <= '0;
         k            <= '0;
         err_q        <= '0;
         for (int i = 0; i < NUM_TAPS; i++)
            coef[i] <= (i == 0) ? {1'b0, {(DATA_W-1){1'b1}}} : '0;
      end else begin
         if ((state == IDLE) && bus.sample_valid) shift_data_q <= bus.sample_in;

         case (state)
            SETTLE: begin
               acc <= '0;
               k   <= '0;
            end
            MAC: begin
               acc <= acc_sum;
               k   <= k + 1'b1;
               if (last_tap) out_sample_q <= sat_val;
            end
            default: ;
         endcase

         // A new error event wins over a simultaneous clear.
         err_q <= (err_q & ~{2{bus.err_clr}}) | {coef_drop, overrun};

         if (bus.coef_we && !busy) begin
            for (int i = 0; i < NUM_TAPS; i++)
               if (bus.coef_addr == 3'(i)) coef[i] <= bus.coef_data;
         end
      end
   end
endmodule

// File: tb/tb_tap_mac_sequencer.sv
// Self-checking bench for tap_mac_sequencer: table of coefficient/tap vectors,
// random vectors against a behavioural MAC model, and timed corner sequences.
module tb_tap_mac_sequencer;
   localparam int DATA_W   = 16;
   localparam int NUM_TAPS = 8;

   localparam int EV_NONE    = 0;
   localparam int EV_OVR     = 1;
   localparam int EV_BUSYW   = 2;
   localparam int EV_RESET   = 3;
   localparam int EV_SAME    = 4;
   localparam int EV_OVR_CLR = 5;

   typedef struct {
      logic [DATA_W*NUM_TAPS-1:0] taps;
      logic [DATA_W*NUM_TAPS-1:0] coefs;
      logic [DATA_W-1:0]          exp_out;
   } vec_t;

   logic clock;
   logic reset_n;
   int   n_chk;
   int   n_pass;

   logic [DATA_W-1:0]          m_coef [NUM_TAPS];
   logic [DATA_W*NUM_TAPS-1:0] taps_v;
   logic [DATA_W-1:0]          exp_q [$];
   vec_t                       vecs [6];

   tap_mac_sequencer_if #(.DATA_W(DATA_W), .NUM_TAPS(NUM_TAPS)) bus ();

   tap_mac_sequencer #(.DATA_W(DATA_W), .NUM_TAPS(NUM_TAPS), .ACC_W(35)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   assign bus.taps_in = taps_v;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
      n_chk++;
      if (act === exp_v) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
   endtask

   function automatic logic [DATA_W-1:0] model_out();
      longint acc;
      acc = 0;
      for (int i = 0; i < NUM_TAPS; i++)
         acc += longint'($signed(taps_v[DATA_W*i +: DATA_W])) * longint'($signed(m_coef[i]));
      acc = acc >>> 15;
      if (acc > 32767)  return 16'h7FFF;
      if (acc < -32768) return 16'h8000;
      return acc[15:0];
   endfunction

   task automatic reset_model();
      for (int i = 0; i < NUM_TAPS; i++) m_coef[i] = (i == 0) ? 16'h7FFF : 16'h0000;
   endtask

   task automatic write_coef(input logic [2:0] a, input logic [DATA_W-1:0] d);
      @(negedge clock);
      bus.coef_we   = 1'b1;
      bus.coef_addr = a;
      bus.coef_data = d;
      @(negedge clock);
      bus.coef_we = 1'b0;
      m_coef[a]   = d;
   endtask

   task automatic clear_err();
      @(negedge clock);
      bus.err_clr = 1'b1;
      @(negedge clock);
      bus.err_clr = 1'b0;
      check("err after err_clr", 32'(bus.err), 32'h0);
   endtask

   // One sample from acceptance (cycle 0) through cycle 20, with an optional
   // event injected during cycle ev_cyc.
   task automatic run_sample(input logic [DATA_W-1:0] s, input logic [DATA_W-1:0] exp_v,
                             input int ev_cyc, input int ev_kind,
                             input logic [2:0] cw_addr, input logic [DATA_W-1:0] cw_data);
      int n_shift;
      int n_ov;
      bit aborted;
      logic [DATA_W-1:0] e;
      n_shift = 0;
      n_ov    = 0;
      aborted = 1'b0;
      exp_q.push_back(exp_v);
      @(negedge clock);
      bus.sample_valid = 1'b1;
      bus.sample_in    = s;
      if (ev_kind == EV_SAME) begin
         bus.coef_we   = 1'b1;
         bus.coef_addr = cw_addr;
         bus.coef_data = cw_data;
      end
      for (int c = 1; c <= 20; c++) begin
         @(negedge clock);
         bus.sample_valid = 1'b0;
         bus.coef_we      = 1'b0;
         bus.err_clr      = 1'b0;
         if (ev_kind == EV_RESET && c == ev_cyc + 1) reset_n = 1'b1;
         if (bus.shift_en) n_shift++;
         if (c == 1) begin
            check("shift_en cycle 1", 32'(bus.shift_en), 32'h1);
            check("shift_data captured", 32'(bus.shift_data), 32'(s));
            check("busy cycle 1", 32'(bus.busy), 32'h1);
         end
         if (c == 11 && !aborted) check("busy cycle 11", 32'(bus.busy), 32'h1);
         if (c == 12) begin
            check("busy cycle 12", 32'(bus.busy), 32'h0);
            if (!aborted) check("shift_data held", 32'(bus.shift_data), 32'(s));
         end
         if (bus.out_valid) begin
            n_ov++;
            check("out_valid cycle", 32'(c), 32'd11);
            if (exp_q.size() == 0) begin
               n_chk++;
               $display("FAIL out_valid with empty scoreboard: cycle %0d", c);
            end else begin
               e = exp_q.pop_front();
               check("out_sample", 32'(bus.out_sample), 32'(e));
            end
         end
         if (c == ev_cyc) begin
            case (ev_kind)
               EV_OVR, EV_OVR_CLR: begin
                  bus.sample_valid = 1'b1;
                  bus.sample_in    = ~s;
                  if (ev_kind == EV_OVR_CLR) bus.err_clr = 1'b1;
               end
               EV_BUSYW: begin
                  bus.coef_we   = 1'b1;
                  bus.coef_addr = cw_addr;
                  bus.coef_data = cw_data;
               end
               EV_RESET: begin
                  reset_n = 1'b0;
                  #1;
                  check("reset shift_en", 32'(bus.shift_en), 32'h0);
                  check("reset busy", 32'(bus.busy), 32'h0);
                  check("reset out_valid", 32'(bus.out_valid), 32'h0);
                  check("reset out_sample", 32'(bus.out_sample), 32'h0);
                  check("reset shift_data", 32'(bus.shift_data), 32'h0);
                  check("reset err", 32'(bus.err), 32'h0);
                  aborted = 1'b1;
                  if (exp_q.size() > 0) void'(exp_q.pop_front());
               end
               default: ;
            endcase
         end
      end
      check("shift_en pulse count", 32'(n_shift), 32'd1);
      check("out_valid pulse count", 32'(n_ov), aborted ? 32'd0 : 32'd1);
      if (n_ov == 0 && exp_q.size() > 0) void'(exp_q.pop_front());
   endtask

   initial begin
      #500000;
      $display("FAIL global timeout");
      $fatal(1);
   end

   initial begin
      n_chk  = 0;
      n_pass = 0;
      vecs[0] = '{taps: {8{16'h7FFF}}, coefs: {8{16'h7FFF}}, exp_out: 16'h7FFF};
      vecs[1] = '{taps: {8{16'h8000}}, coefs: {8{16'h7FFF}}, exp_out: 16'h8000};
      vecs[2] = '{taps: {16'h1234, 16'hBEEF, 16'h7777, 16'h8001, 16'h2000, 16'h0F0F, 16'hCAFE, 16'h5555},
                  coefs: {16'h0, 16'h0, 16'h0, 16'h0, 16'h4000, 16'h0, 16'h0, 16'h0}, exp_out: 16'h1000};
      vecs[3] = '{taps: {{7{16'h0777}}, 16'h1000},
                  coefs: {{7{16'h0000}}, 16'h8000}, exp_out: 16'hF000};
      vecs[4] = '{taps: {{6{16'h3333}}, 16'h0200, 16'h0100},
                  coefs: {{6{16'h0000}}, 16'h4000, 16'h4000}, exp_out: 16'h0180};
      vecs[5] = '{taps: {{7{16'h1111}}, 16'hFFFF},
                  coefs: {{7{16'h0000}}, 16'h7FFF}, exp_out: 16'hFFFF};

      reset_n          = 1'b0;
      bus.sample_valid = 1'b0;
      bus.sample_in    = '0;
      bus.coef_we      = 1'b0;
      bus.coef_addr    = '0;
      bus.coef_data    = '0;
      bus.err_clr      = 1'b0;
      taps_v           = '0;
      reset_model();
      repeat (3) @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
      check("post-reset busy", 32'(bus.busy), 32'h0);
      check("post-reset out_valid", 32'(bus.out_valid), 32'h0);
      check("post-reset shift_en", 32'(bus.shift_en), 32'h0);
      check("post-reset out_sample", 32'(bus.out_sample), 32'h0);
      check("post-reset shift_data", 32'(bus.shift_data), 32'h0);
      check("post-reset err", 32'(bus.err), 32'h0);

      // Reset coefficients pass tap 0 through.
      taps_v = {8{16'h1000}};
      run_sample(16'hABCD, 16'h0FFF, 0, EV_NONE, 3'd0, 16'h0);

      for (int v = 0; v < 6; v++) begin
         for (int j = 0; j < NUM_TAPS; j++) write_coef(3'(j), vecs[v].coefs[DATA_W*j +: DATA_W]);
         taps_v = vecs[v].taps;
         run_sample(16'(v * 17 + 3), vecs[v].exp_out, 0, EV_NONE, 3'd0, 16'h0);
      end

      for (int r = 0; r < 3; r++) begin
         for (int j = 0; j < NUM_TAPS; j++) write_coef(3'(j), 16'($urandom));
         taps_v = {$urandom, $urandom, $urandom, $urandom};
         run_sample(16'($urandom), model_out(), 0, EV_NONE, 3'd0, 16'h0);
      end

      for (int j = 0; j < NUM_TAPS; j++) write_coef(3'(j), (j == 0) ? 16'h7FFF : 16'h0000);
      taps_v = {8{16'h1000}};
      run_sample(16'h0101, model_out(), 5, EV_OVR, 3'd0, 16'h0);
      check("err after overrun", 32'(bus.err), 32'h1);
      clear_err();

      run_sample(16'h0202, model_out(), 6, EV_BUSYW, 3'd0, 16'h4000);
      check("err after busy coef write", 32'(bus.err), 32'h2);
      // Coefficient must be unchanged; overrun together with err_clr keeps bit0.
      run_sample(16'h0303, model_out(), 5, EV_OVR_CLR, 3'd0, 16'h0);
      check("err set wins over clear", 32'(bus.err), 32'h1);
      clear_err();

      m_coef[1] = 16'h4000;
      run_sample(16'h0404, model_out(), 0, EV_SAME, 3'd1, 16'h4000);

      run_sample(16'h0505, model_out(), 7, EV_RESET, 3'd0, 16'h0);
      reset_model();
      run_sample(16'h0606, model_out(), 0, EV_NONE, 3'd0, 16'h0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/tap_mac_sequencer.md
TAP_MAC_SEQUENCER -- requirements
Module: tap_mac_sequencer

Interface
REQ-001 Parameter DATA_W, default 16, sample and coefficient width (signed two's complement).
REQ-002 Parameter NUM_TAPS, default 8, number of delay-line taps consumed.
REQ-003 Parameter ACC_W, default 35, accumulator width (2*DATA_W + ceil(log2 NUM_TAPS)).
REQ-004 Clocking: one clock; reset is asynchronous and active-low.
REQ-005 clock  in  1  single clock, all state on rising edge.
REQ-006 reset_n  in  1  asynchronous active-low reset.
REQ-007 sample_valid  in  1  one-cycle strobe: new audio sample on sample_in.
REQ-008 sample_in  in  DATA_W  new audio sample.
REQ-009 shift_en  out  1  clock enable to the tapped delay line (one cycle per accepted sample).
REQ-010 shift_data  out  DATA_W  sample presented to delay line shiftin, registered.
REQ-011 taps_in  in  DATA_W*NUM_TAPS  tap bus from delay line; tap i = taps_in[DATA_W*i +: DATA_W].
REQ-012 coef_we  in  1  coefficient write strobe.
REQ-013 coef_addr  in  3  coefficient index 0..NUM_TAPS-1.
REQ-014 coef_data  in  DATA_W  signed Q1.15 coefficient.
REQ-015 busy  out  1  high while a sample is being processed.
REQ-016 out_valid  out  1  one-cycle strobe: out_sample valid.
REQ-017 out_sample  out  DATA_W  filtered/echo output, held until next out_valid.
REQ-018 err  out  2  sticky: bit0 sample overrun, bit1 coefficient write dropped.
REQ-019 err_clr  in  1  synchronous clear of err (both bits).

Function
REQ-020 States: IDLE, SHIFT, SETTLE, MAC, OUT; IDLE -> SHIFT on sample_valid; SHIFT -> SETTLE; SETTLE -> MAC; MAC -> OUT after NUM_TAPS cycles; OUT -> IDLE.
REQ-021 On acceptance in IDLE, sample_in captured into shift_data; shift_en high exactly during SHIFT.
REQ-022 SETTLE is one idle cycle allowing the delay line's registered taps to update; accumulator cleared in SETTLE.
REQ-023 MAC: tap counter k = 0..NUM_TAPS-1, one tap per cycle; acc += sign-extended(tap_k * coef_k) (full DATA_W x DATA_W signed product).
REQ-024 OUT: out_sample = saturate(acc >>> 15) to [-2^(DATA_W-1), 2^(DATA_W-1)-1]; out_valid high for this one cycle.
REQ-025 Latency: sample_valid in cycle 0 -> shift_en cycle 1, SETTLE cycle 2, MAC cycles 3..10, out_valid cycle 11 (default NUM_TAPS=8).
REQ-026 busy high in every non-IDLE state (cycles 1..11); next sample accepted earliest in cycle 12.
REQ-027 sample_valid while busy: sample dropped, no shift_en, err[0] set; processing in progress unaffected.
REQ-028 Coefficient bank: NUM_TAPS registers; coef_we while !busy writes coef_data to coef_addr in the same edge.
REQ-029 coef_we while busy: write dropped, err[1] set; coef_addr >= NUM_TAPS ignored without error.
REQ-030 sample_valid and coef_we in the same IDLE cycle: both take effect; new coefficient used by this sample's MAC.
REQ-031 err_clr and a new error event in the same cycle: set wins.
REQ-032 Accumulator never wraps for default widths; saturation applied only at OUT.

Reset
REQ-033 reset_n low: state IDLE, shift_en 0, shift_data 0, busy 0, out_valid 0, out_sample 0, err 0, acc 0, k 0.
REQ-034 Reset coefficients: coef_0 = 0x7FFF, all others 0 (passthrough of tap 0).
REQ-035 Reset asserted mid-operation aborts immediately; no out_valid issued for the aborted sample; after release, block idles until the next sample_valid.

Verification
REQ-036 Post-reset, taps all 0x1000, one sample_valid -> shift_en cycle 1 only, out_valid cycle 11, out_sample 0x0FFF.
REQ-037 Coefs all 0x7FFF, taps all 0x7FFF -> out_sample saturates 0x7FFF; taps all 0x8000 -> 0x8000.
REQ-038 coef_k = 0x4000 only k=3, tap3 = 0x2000, others arbitrary -> out_sample 0x1000.
REQ-039 Second sample_valid in cycle 5 -> dropped, err = 01, out_valid still cycle 11; err_clr -> err = 00.
REQ-040 coef_we in cycle 6 (busy) -> err = 10, coefficient unchanged on next sample; coef_we in IDLE with sample_valid same cycle -> new coef applied.
REQ-041 reset_n low in cycle 7 -> all outputs 0 immediately, no out_valid; next sample processed with 11-cycle latency.
